// File: rtl/spc_play_sequencer.sv
// spc_play_sequencer: one-song-at-a-time transport for the SPC player (load -> parse -> play -> fade),
// with debounced next/prev skips, play-time counters and load-failure retry.
module spc_play_sequencer #(
    parameter int TICK_CYCLES      = 2_700_000,
    parameter int DEBOUNCE_CYCLES  = 540_000,
    parameter int MIN_PLAY_TICKS   = 10,
    parameter int FADE_STEP_CYCLES = 105_469,
    parameter int ERR_HOLD_TICKS   = 10
) (
    input  logic        sys_clk,
    input  logic        resetn,
    input  logic        btn_next,
    input  logic        btn_prev,
    input  logic [15:0] total,
    input  logic [15:0] length,
    output logic        loader_start,
    input  logic        loader_done,
    input  logic        loader_fail,
    output logic        parser_start,
    input  logic        parser_done,
    output logic        spc_reset,
    output logic        spc_ready,
    output logic [15:0] song,
    output logic [7:0]  gain,
    output logic [5:0]  minute,
    output logic [5:0]  second,
    output logic [15:0] played,
    output logic [2:0]  state_dbg
);
    localparam int TW = $clog2(TICK_CYCLES + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int FW = $clog2(FADE_STEP_CYCLES + 1);
    localparam int EH = ERR_HOLD_TICKS * TICK_CYCLES;
    localparam int EW = $clog2(EH + 1);

    typedef enum logic [2:0] {
        S_START = 3'd0, S_LOAD = 3'd1, S_PARSE = 3'd2, S_PLAY = 3'd3, S_FADE = 3'd4, S_ERROR = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   song_q, song_d, fail_q, fail_d, played_q, played_d, ttot_q, ttot_d;
    logic [7:0]    gain_q, gain_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [3:0]    tenths_q, tenths_d;
    logic [5:0]    sec_q, sec_d, min_q, min_d;
    logic [FW-1:0] fade_q, fade_d;
    logic [EW-1:0] err_q, err_d;
    logic          pstart_q, pstart_d;
    logic [1:0]    s1_q, s1_d, s2_q, s2_d, lvl_q, lvl_d, pulse_q, pulse_d;
    logic [DW-1:0] db_q [2];
    logic [DW-1:0] db_d [2];
    logic          nxt, prv, btn, run, tick, sec_ev, fstep, hold_done;
    logic [15:0]   tot, song_inc, song_btn;

    always_comb begin
        s1_d = {btn_prev, btn_next};
        s2_d = s1_q;
        lvl_d = lvl_q;
        pulse_d = '0;
        for (int i = 0; i < 2; i++) begin
            db_d[i] = (s2_q[i] == lvl_q[i]) ? '0 : db_q[i] + 1'b1;
            if (s2_q[i] != lvl_q[i] && db_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                db_d[i] = '0;
                lvl_d[i] = s2_q[i];
                pulse_d[i] = s2_q[i];
            end
        end
        // simultaneous next+prev cancel each other
        nxt = pulse_q[0] & ~pulse_q[1];
        prv = pulse_q[1] & ~pulse_q[0];
        btn = nxt | prv;
        tot = (total == 16'd0) ? 16'd1 : total;
        song_inc = ({1'b0, song_q} + 17'd1 >= {1'b0, tot}) ? 16'd0 : song_q + 16'd1;
        song_btn = nxt ? song_inc : (song_q == 16'd0) ? tot - 16'd1 : song_q - 16'd1;
        run = state_q == S_PLAY || state_q == S_FADE;
        tick = run && tick_q == TW'(TICK_CYCLES - 1);
        sec_ev = tick && tenths_q == 4'd9;
        tick_d = !run ? tick_q : tick ? '0 : tick_q + 1'b1;
        tenths_d = !tick ? tenths_q : sec_ev ? 4'd0 : tenths_q + 4'd1;
        ttot_d = (tick && ttot_q != 16'hFFFF) ? ttot_q + 16'd1 : ttot_q;
        sec_d = !sec_ev ? sec_q : (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
        min_d = (sec_ev && sec_q == 6'd59 && min_q != 6'd63) ? min_q + 6'd1 : min_q;
        played_d = (sec_ev && played_q != 16'hFFFF) ? played_q + 16'd1 : played_q;
        fstep = state_q == S_FADE && fade_q == FW'(FADE_STEP_CYCLES - 1);
        fade_d = (state_q != S_FADE || fstep) ? '0 : fade_q + 1'b1;
        hold_done = err_q == EW'(EH - 1);
        err_d = (state_q != S_ERROR) ? '0 : hold_done ? err_q : err_q + 1'b1;
        state_d = state_q;
        song_d = song_q;
        fail_d = fail_q;
        pstart_d = 1'b0;
        case (state_q)
            S_START: state_d = S_LOAD;
            S_LOAD: begin
                if (loader_fail) begin
                    state_d = S_ERROR;
                    fail_d = (fail_q == 16'hFFFF) ? fail_q : fail_q + 16'd1;
                end else if (loader_done) begin
                    state_d = S_PARSE;
                    pstart_d = 1'b1;
                end
            end
            S_PARSE: begin
                if (parser_done) begin
                    state_d = S_PLAY;
                    fail_d = '0;
                    tick_d = '0;
                    tenths_d = '0;
                    sec_d = '0;
                    min_d = '0;
                    played_d = '0;
                    ttot_d = '0;
                end
            end
            S_PLAY: begin
                if (btn && ttot_q >= 16'(MIN_PLAY_TICKS)) begin
                    state_d = S_START;
                    song_d = song_btn;
                end else if (length != 16'd0 && played_q >= length) begin
                    state_d = S_FADE;
                end
            end
            S_FADE: begin
                if (gain_q == 8'd0) begin
                    state_d = S_START;
                    song_d = song_inc;
                end
            end
            S_ERROR: begin
                if (hold_done && fail_q < tot) begin
                    state_d = S_START;
                    song_d = song_inc;
                end else if (hold_done && btn) begin
                    state_d = S_START;
                    song_d = song_btn;
                    fail_d = '0;
                end
            end
            default: state_d = S_START;
        endcase
        gain_d = (state_d != S_FADE) ? 8'd255 : gain_q - {7'd0, fstep};
    end

    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            state_q <= S_START;
            song_q <= '0;
            fail_q <= '0;
            played_q <= '0;
            ttot_q <= '0;
            gain_q <= 8'd255;
            tick_q <= '0;
            tenths_q <= '0;
            sec_q <= '0;
            min_q <= '0;
            fade_q <= '0;
            err_q <= '0;
            pstart_q <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
            lvl_q <= '0;
            pulse_q <= '0;
            db_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            song_q <= song_d;
            fail_q <= fail_d;
            played_q <= played_d;
            ttot_q <= ttot_d;
            gain_q <= gain_d;
            tick_q <= tick_d;
            tenths_q <= tenths_d;
            sec_q <= sec_d;
            min_q <= min_d;
            fade_q <= fade_d;
            err_q <= err_d;
            pstart_q <= pstart_d;
            s1_q <= s1_d;
            s2_q <= s2_d;
            lvl_q <= lvl_d;
            pulse_q <= pulse_d;
            db_q <= db_d;
        end
    end

    // gated so the start pulse stays low while reset is held
    assign loader_start = resetn && state_q == S_START;
    assign parser_start = pstart_q;
    assign spc_reset = state_q == S_START;
    assign spc_ready = state_q == S_PLAY || state_q == S_FADE;
    assign song = song_q;
    assign gain = gain_q;
    assign minute = min_q;
    assign second = sec_q;
    assign played = played_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_spc_play_sequencer.sv
// tb_spc_play_sequencer: directed stimulus; outputs checked every cycle against an
// elapsed-time model of the sequencer, plus hand-computed literal checkpoints.
module tb_spc_play_sequencer;
    localparam int TICK = 10;
    localparam int DEB  = 4;
    localparam int MINT = 2;
    localparam int FSC  = 1;
    localparam int ERRH = 2;

    logic        sys_clk, resetn, btn_next, btn_prev;
    logic [15:0] total, length;
    logic        loader_start, loader_done, loader_fail, parser_start, parser_done;
    logic        spc_reset, spc_ready;
    logic [15:0] song, played;
    logic [7:0]  gain;
    logic [5:0]  minute, second;
    logic [2:0]  state_dbg;

    int n_vec, n_err;
    bit chk_en;
    int m_st, m_song, m_fail, m_run, m_fade, m_err, m_os, m_tot, m_secs, c_secs;
    bit m_ps, go_n, go_p;
    bit [1:0] m_pl, m_lvl;
    logic [1:0] bh [2];
    logic [DEB-1:0] sh [2];

    spc_play_sequencer #(
        .TICK_CYCLES(TICK), .DEBOUNCE_CYCLES(DEB), .MIN_PLAY_TICKS(MINT),
        .FADE_STEP_CYCLES(FSC), .ERR_HOLD_TICKS(ERRH)
    ) dut (
        .sys_clk(sys_clk), .resetn(resetn), .btn_next(btn_next), .btn_prev(btn_prev),
        .total(total), .length(length), .loader_start(loader_start), .loader_done(loader_done),
        .loader_fail(loader_fail), .parser_start(parser_start), .parser_done(parser_done),
        .spc_reset(spc_reset), .spc_ready(spc_ready), .song(song), .gain(gain),
        .minute(minute), .second(second), .played(played), .state_dbg(state_dbg)
    );

    initial begin
        sys_clk = 0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            if (n_err < 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
            n_err++;
        end
    endtask

    function automatic int step(input int s, input bit fwd, input int t);
        return fwd ? ((s + 1 >= t) ? 0 : s + 1) : ((s == 0) ? t - 1 : s - 1);
    endfunction

    // Model: play time is derived from cycles spent in PLAY/FADE, fade gain from cycles in FADE,
    // debounce from a window of the last DEB synchronised samples.
    initial forever begin
        @(posedge sys_clk);
        if (!resetn) begin
            m_st = 0; m_song = 0; m_fail = 0; m_run = 0; m_fade = 0; m_err = 0; m_ps = 0;
            m_pl = 0; m_lvl = 0;
            for (int b = 0; b < 2; b++) begin
                bh[b] = 0;
                sh[b] = 0;
            end
        end else begin
            m_os = m_st;
            m_tot = (total == 0) ? 1 : int'(total);
            go_n = m_pl[0] && !m_pl[1];
            go_p = m_pl[1] && !m_pl[0];
            m_secs = m_run / (TICK * 10);
            m_ps = 0;
            case (m_os)
                0: m_st = 1;
                1: if (loader_fail) begin
                       m_st = 5; m_err = 0;
                       if (m_fail < 65535) m_fail++;
                   end else if (loader_done) begin
                       m_st = 2; m_ps = 1;
                   end
                2: if (parser_done) begin
                       m_st = 3; m_fail = 0; m_run = 0;
                   end
                3: if ((go_n || go_p) && m_run / TICK >= MINT) begin
                       m_song = step(m_song, go_n, m_tot); m_st = 0;
                   end else if (length != 0 && m_secs >= int'(length)) begin
                       m_st = 4; m_fade = 0;
                   end
                4: if (255 - m_fade / FSC <= 0) begin
                       m_song = step(m_song, 1, m_tot); m_st = 0;
                   end
                5: if (m_err >= ERRH * TICK - 1) begin
                       if (m_fail < m_tot) begin
                           m_song = step(m_song, 1, m_tot); m_st = 0;
                       end else if (go_n || go_p) begin
                           m_song = step(m_song, go_n, m_tot); m_fail = 0; m_st = 0;
                       end
                   end
                default: m_st = 0;
            endcase
            if (m_os == 3 || m_os == 4) m_run++;
            if (m_os == 4) m_fade++;
            if (m_os == 5) m_err++;
            for (int b = 0; b < 2; b++) begin
                sh[b] = {sh[b][DEB-2:0], bh[b][1]};
                m_pl[b] = 0;
                if (sh[b] == {DEB{~m_lvl[b]}}) begin
                    m_lvl[b] = ~m_lvl[b];
                    m_pl[b] = m_lvl[b];
                end
                bh[b] = {bh[b][0], (b == 1) ? btn_prev : btn_next};
            end
        end
    end

    initial forever begin
        @(negedge sys_clk);
        if (chk_en) begin
            c_secs = m_run / (TICK * 10);
            chk("state_dbg", state_dbg, m_st);
            chk("song", song, m_song);
            chk("gain", gain, (m_st == 4) ? 255 - m_fade / FSC : 255);
            chk("spc_reset", spc_reset, m_st == 0);
            chk("spc_ready", spc_ready, m_st == 3 || m_st == 4);
            chk("loader_start", loader_start, m_st == 0 && resetn);
            chk("parser_start", parser_start, m_ps);
            chk("played", played, (c_secs > 65535) ? 65535 : c_secs);
            chk("second", second, c_secs % 60);
            chk("minute", minute, (c_secs / 60 > 63) ? 63 : c_secs / 60);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_state(input int s, input int maxc);
        for (int i = 0; i < maxc && state_dbg != s; i++) cyc(1);
        chk("wait_state", state_dbg, s);
    endtask

    task automatic load_ok();
        wait_state(1, 10);
        loader_done = 1;
        cyc(1);
        loader_done = 0;
        wait_state(2, 5);
        parser_done = 1;
        cyc(1);
        parser_done = 0;
        chk("ready_after_parse", spc_ready, 1);
    endtask

    task automatic press(input bit nx, input bit pv, input int hold);
        btn_next = nx;
        btn_prev = pv;
        cyc(hold);
        btn_next = 0;
        btn_prev = 0;
        cyc(8);
    endtask

    initial begin
        n_vec = 0; n_err = 0; chk_en = 0;
        resetn = 0; btn_next = 0; btn_prev = 0; total = 3; length = 2;
        loader_done = 0; loader_fail = 0; parser_done = 0;
        cyc(1);
        chk_en = 1;
        cyc(1);
        chk("rst_state", state_dbg, 0);
        chk("rst_gain", gain, 255);
        chk("rst_spc_reset", spc_reset, 1);
        chk("rst_loader_start", loader_start, 0);
        resetn = 1;
        // normal flow with fade and auto-advance
        load_ok();
        wait_state(4, 300);
        chk("fade_played", played, 2);
        cyc(255);
        chk("fade_gain0", gain, 0);
        chk("fade_still", state_dbg, 4);
        cyc(1);
        chk("adv_song", song, 1);
        chk("adv_loader_start", loader_start, 1);
        chk("adv_spc_reset", spc_reset, 1);
        cyc(1);
        chk("adv_spc_reset_off", spc_reset, 0);
        length = 0;
        // wrap in both directions, then a cancelled double press
        load_ok(); cyc(30); press(1, 0, 5); wait_state(1, 20);
        chk("next_1to2", song, 2);
        load_ok(); cyc(30); press(1, 0, 5); wait_state(1, 20);
        chk("next_wrap", song, 0);
        load_ok(); cyc(30); press(0, 1, 5); wait_state(1, 20);
        chk("prev_wrap", song, 2);
        load_ok(); cyc(30); press(1, 1, 5); cyc(5);
        chk("both_state", state_dbg, 3);
        chk("both_song", song, 2);
        press(1, 0, 5); wait_state(1, 20);
        chk("next_2to0", song, 0);
        // early skip dropped at tick_total=1, accepted at tick_total=2
        load_ok(); cyc(8); press(1, 0, 5);
        chk("early_drop", state_dbg, 3);
        press(1, 0, 5); wait_state(1, 20);
        chk("min_ticks_skip", song, 1);
        // 3-cycle glitch
        load_ok(); cyc(30); press(1, 0, 3);
        chk("glitch_state", state_dbg, 3);
        chk("glitch_song", song, 1);
        // load failures with total=2
        total = 2;
        press(1, 0, 5); wait_state(1, 20);
        chk("t2_song", song, 0);
        loader_fail = 1; cyc(1); loader_fail = 0;
        chk("fail1_err", state_dbg, 5);
        wait_state(1, 40);
        chk("retry_song", song, 1);
        loader_fail = 1; cyc(1); loader_fail = 0;
        cyc(40);
        chk("fail2_stuck", state_dbg, 5);
        press(1, 0, 5); wait_state(1, 20);
        chk("err_btn_song", song, 0);
        loader_done = 1; loader_fail = 1; cyc(1); loader_done = 0; loader_fail = 0;
        chk("fail_wins", state_dbg, 5);
        wait_state(1, 40);
        chk("retry2_song", song, 1);
        // reset in the middle of a fade
        length = 1;
        load_ok(); wait_state(4, 200); cyc(155);
        chk("mid_gain", gain, 100);
        resetn = 0; cyc(1);
        chk("mrst_gain", gain, 255);
        chk("mrst_spc_reset", spc_reset, 1);
        chk("mrst_ready", spc_ready, 0);
        chk("mrst_song", song, 0);
        chk("mrst_state", state_dbg, 0);
        resetn = 1;
        // 600 ticks of play without auto-advance
        length = 0; total = 3;
        load_ok(); cyc(6000);
        chk("tmr_minute", minute, 1);
        chk("tmr_second", second, 0);
        chk("tmr_played", played, 60);
        chk("tmr_state", state_dbg, 3);
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
